alu_share_arb: RTL

- Two-requester arbiter and sequencer for one shared combinational ALU instance, for example the main datapath and an address/branch-compare helper.
- Accepts operation requests over valid/ready handshakes and grants them round-robin.
- Drives the ALU from registered operands for one cycle, then captures the result and zero flag.
- Returns the captured result on a single tagged response channel, with back-pressure.

---
 rtl/alu_share_arb_if.sv | 49 ++++
 rtl/alu_share_arb.sv | 98 +++++++++
 2 files changed

// File: rtl/alu_share_arb_if.sv
// Request, shared-ALU and response bundle for alu_share_arb.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface alu_share_arb_if #(
  parameter int DW  = 32,
  parameter int OPW = 4
);
  logic           req0_valid;
  logic           req0_ready;
  logic [OPW-1:0] req0_op;
  logic [DW-1:0]  req0_a;
  logic [DW-1:0]  req0_b;

  logic           req1_valid;
  logic           req1_ready;
  logic [OPW-1:0] req1_op;
  logic [DW-1:0]  req1_a;
  logic [DW-1:0]  req1_b;

  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [DW-1:0]  alu_c;
  logic           alu_zero;

  logic           resp_valid;
  logic           resp_id;
  logic [DW-1:0]  resp_c;
  logic           resp_zero;
  logic           resp_ready;
  logic           busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_c, alu_zero, resp_ready,
    output req0_ready, req1_ready,
    output alu_op, alu_a, alu_b,
    output resp_valid, resp_id, resp_c, resp_zero, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_c, alu_zero, resp_ready,
    input  req0_ready, req1_ready,
    input  alu_op, alu_a, alu_b,
    input  resp_valid, resp_id, resp_c, resp_zero, busy
  );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two
// requesters: IDLE grants, EXEC drives the ALU for one cycle, RESP holds the result.
module alu_share_arb #(
  parameter int             DW      = 32,
  parameter int             OPW     = 4,
  parameter logic [OPW-1:0] ALU_NOP = '0
) (
  input logic             clk,
  input logic             rst,
  alu_share_arb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state;
  logic           last_grant;
  logic           grant_id;
  logic           accept;
  logic [OPW-1:0] op_q;
  logic [DW-1:0]  a_q;
  logic [DW-1:0]  b_q;
  logic           id_q;
  logic [DW-1:0]  c_q;
  logic           zero_q;
  logic           valid_q;
  logic           busy_q;

  // On contention the requester that did not win last time gets the grant.
  always_comb begin
    grant_id = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) grant_id = ~last_grant;
  end

  // Readys are combinational so a request is accepted in the cycle it is shown;
  // rst gates them because the async reset alone would leave the FSM in IDLE.
  assign bus.req0_ready = (state == IDLE) && !rst && bus.req0_valid && !grant_id;
  assign bus.req1_ready = (state == IDLE) && !rst && bus.req1_valid &&  grant_id;
  assign accept         = bus.req0_ready || bus.req1_ready;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_q       <= ALU_NOP;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      c_q        <= '0;
      zero_q     <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= EXEC;
            busy_q     <= 1'b1;
            last_grant <= grant_id;
            id_q       <= grant_id;
            op_q       <= grant_id ? bus.req1_op : bus.req0_op;
            a_q        <= grant_id ? bus.req1_a  : bus.req0_a;
            b_q        <= grant_id ? bus.req1_b  : bus.req0_b;
          end
        end
        EXEC: begin
          // Operand registers return to quiet values as the result is captured.
          c_q     <= bus.alu_c;
          zero_q  <= bus.alu_zero;
          valid_q <= 1'b1;
          op_q    <= ALU_NOP;
          a_q     <= '0;
          b_q     <= '0;
          state   <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.alu_op     = op_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_id    = id_q;
  assign bus.resp_c     = c_q;
  assign bus.resp_zero  = zero_q;
  assign bus.busy       = busy_q;

endmodule
